seg_scan_driver: RTL and testbench

- Time-multiplexed scan controller for the 8-digit seven-segment display. Registers a packed hex value and steps through the digit positions, one slot at a time.
- In each slot it presents one nibble on num and its digit index on sel. These feed the existing combinational nibble-to-segment and anode decoder.
- Adds anti-ghost blanking at every digit change and optional leading-zero suppression.
- Sits between the datapath (the producer of value/load) and the display decoder.

---
 rtl/seg_scan_driver.sv | 92 +++++++++
 tb/tb_seg_scan_driver.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_driver.sv
// Time-multiplexed scan controller for a multi-digit seven-segment display.
// Steps through digit slots, presenting one nibble and its index, with guard blanking and leading-zero suppression.
module seg_scan_driver #(
  parameter int NUM_DIGITS   = 8,
  parameter int SLOT_CYCLES  = 100000,
  parameter int GUARD_CYCLES = 1000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic                    load,
  input  logic                    lz_en,
  output logic [3:0]              num,
  output logic [2:0]              sel,
  output logic                    blank,
  output logic                    frame_tick
);

  localparam int              CW        = $clog2(SLOT_CYCLES);
  localparam logic [CW-1:0]   LAST_CNT  = CW'(SLOT_CYCLES - 1);
  localparam logic [CW:0]     GUARD_LIM = (CW+1)'(GUARD_CYCLES);
  localparam logic [2:0]      LAST_SEL  = 3'(NUM_DIGITS - 1);

  logic [4*NUM_DIGITS-1:0] shadow;
  logic [CW-1:0]           cnt;
  logic [CW-1:0]           cnt_next;
  logic [2:0]              sel_next;
  logic [3:0]              num_next;
  logic                    lz_flag;
  logic                    lz_next;
  logic                    blank_next;
  logic                    tick_next;
  logic                    slot_end;
  logic [NUM_DIGITS-1:0]   upper_zero;

  // upper_zero[i]: shadow nibbles i..NUM_DIGITS-1 are all zero.
  always_comb begin : zero_scan
    for (int i = 0; i < NUM_DIGITS; i++) begin
      upper_zero[i] = ~|(shadow >> (4 * i));
    end
  end

  always_comb begin : next_state
    // NOTE: every signal driven here gets a default first, so no path leaves one unassigned and infers a latch.
    slot_end = (cnt == LAST_CNT);
    cnt_next = cnt + CW'(1);
    sel_next = sel;
    num_next = num;
    lz_next  = lz_flag;

    if (slot_end) begin
      cnt_next = '0;
      sel_next = (sel == LAST_SEL) ? 3'd0 : sel + 3'd1;
      lz_next  = 1'b0;
      // Entry into the new slot samples the current (pre-load) shadow and lz_en.
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (sel_next == 3'(i)) begin
          num_next = shadow[4*i +: 4];
          lz_next  = lz_en && (i > 0) && upper_zero[i];
        end
      end
    end

    blank_next = ({1'b0, cnt_next} < GUARD_LIM) || lz_next;
    tick_next  = slot_end && (sel == LAST_SEL);
  end

  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values;
    // this is what makes a load on a slot boundary leave that boundary on the old shadow.
    if (rst) begin
      shadow     <= '0;
      cnt        <= '0;
      sel        <= 3'd0;
      num        <= 4'd0;
      lz_flag    <= 1'b0;
      blank      <= 1'b1;
      frame_tick <= 1'b0;
    end else begin
      if (load) begin
        shadow <= value;
      end
      cnt        <= cnt_next;
      sel        <= sel_next;
      num        <= num_next;
      lz_flag    <= lz_next;
      blank      <= blank_next;
      frame_tick <= tick_next;
    end
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Self-checking bench for seg_scan_driver: an 8-digit and a 4-digit instance against a time-based reference model.
module tb_seg_scan_driver;

  localparam int SLOT  = 4;
  localparam int GUARD = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        load;
  logic        lz_en;
  logic [31:0] value;

  logic [3:0] num8, num4;
  logic [2:0] sel8, sel4;
  logic       blank8, blank4, tick8, tick4;

  int tests = 0;
  int fails = 0;

  // Reference model state: cycles since reset exit, shadow copy, nibble and suppression captured at slot entry.
  int          m8_t, m4_t;
  logic [31:0] m8_sh, m4_sh;
  logic [3:0]  m8_nib, m4_nib;
  logic        m8_lz, m4_lz;

  logic [3:0] full_tab [8] = '{4'h8, 4'h7, 4'h6, 4'h5, 4'h4, 4'h3, 4'h2, 4'h1};
  logic [3:0] nolz_tab [8] = '{4'h5, 4'h0, 4'hA, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
  logic [3:0] beef_tab [4] = '{4'hF, 4'hE, 4'hE, 4'hB};

  seg_scan_driver #(.NUM_DIGITS(8), .SLOT_CYCLES(SLOT), .GUARD_CYCLES(GUARD)) dut8 (
    .clk(clk), .rst(rst), .value(value), .load(load), .lz_en(lz_en),
    .num(num8), .sel(sel8), .blank(blank8), .frame_tick(tick8)
  );

  seg_scan_driver #(.NUM_DIGITS(4), .SLOT_CYCLES(SLOT), .GUARD_CYCLES(GUARD)) dut4 (
    .clk(clk), .rst(rst), .value(value[15:0]), .load(load), .lz_en(lz_en),
    .num(num4), .sel(sel4), .blank(blank4), .frame_tick(tick4)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h (time %0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_step(input int n, inout int t, inout logic [31:0] sh,
                            inout logic [3:0] nib, inout logic lz);
    logic [31:0] mask;
    int          d;
    mask = (n >= 8) ? 32'hFFFF_FFFF : ((32'h1 << (4 * n)) - 32'h1);
    if (rst) begin
      t   = 0;
      sh  = 32'h0;
      nib = 4'h0;
      lz  = 1'b0;
    end else begin
      t++;
      if (t % SLOT == 0) begin
        d   = (t / SLOT) % n;
        nib = 4'((sh >> (4 * d)) & 32'hF);
        lz  = lz_en && (d > 0) && ((sh >> (4 * d)) == 32'h0);
      end
      if (load) sh = value & mask;
    end
  endtask

  task automatic check_dut(input string name, input int n, input int t, input logic [3:0] nib,
                           input logic lz, input logic [2:0] s, input logic [3:0] nm,
                           input logic b, input logic tk);
    check({name, ".sel"},        32'(s),  32'((t / SLOT) % n));
    check({name, ".num"},        32'(nm), 32'(nib));
    check({name, ".blank"},      32'(b),  32'(((t % SLOT) < GUARD) || lz));
    check({name, ".frame_tick"}, 32'(tk), 32'((t > 0) && (t % (n * SLOT) == 0)));
  endtask

  task automatic step();
    @(posedge clk);
    model_step(8, m8_t, m8_sh, m8_nib, m8_lz);
    model_step(4, m4_t, m4_sh, m4_nib, m4_lz);
    @(negedge clk);
    check_dut("d8", 8, m8_t, m8_nib, m8_lz, sel8, num8, blank8, tick8);
    check_dut("d4", 4, m4_t, m4_nib, m4_lz, sel4, num4, blank4, tick4);
  endtask

  // Advance until the 8-digit frame position (cycle within a 32-cycle frame) equals ph.
  task automatic run_until(input int ph);
    for (int i = 0; i < 64; i++) begin
      if (m8_t % 32 == ph) break;
      step();
    end
  endtask

  initial begin
    rst   = 1'b1;
    load  = 1'b0;
    lz_en = 1'b0;
    value = 32'h0;
    m8_t = 0; m8_sh = 0; m8_nib = 0; m8_lz = 0;
    m4_t = 0; m4_sh = 0; m4_nib = 0; m4_lz = 0;

    // Reset held three cycles, then release and watch the first frame.
    repeat (3) step();
    check("rst.sel",   32'(sel8),   32'd0);
    check("rst.num",   32'(num8),   32'd0);
    check("rst.blank", 32'(blank8), 32'd1);
    check("rst.tick",  32'(tick8),  32'd0);
    rst = 1'b0;
    for (int c = 1; c <= 32; c++) begin
      step();
      if (c <= 3) check("rst.guard_off", 32'(blank8), 32'd0);
      if (c == 4) check("rst.sel_c4", 32'(sel8), 32'd1);
      if (c < 32) check("rst.no_tick", 32'(tick8), 32'd0);
      else        check("rst.first_tick", 32'(tick8), 32'd1);
    end

    // Full scan: load while sel = 7, expect reversed digits next frame.
    run_until(28);
    value = 32'h1234_5678;
    load  = 1'b1;
    step();
    load  = 1'b0;
    run_until(0);
    for (int i = 0; i < 32; i++) begin
      if (i == 0) check("scan.tick", 32'(tick8), 32'd1);
      check("scan.sel", 32'(sel8), 32'(i / 4));
      if (i % 4 == 0) begin
        check("scan.num",   32'(num8),   32'(full_tab[i / 4]));
        check("scan.guard", 32'(blank8), 32'd1);
      end else begin
        check("scan.shown", 32'(blank8), 32'd0);
      end
      step();
    end

    // Leading-zero suppression on, then off.
    lz_en = 1'b1;
    run_until(28);
    value = 32'h0000_0A05;
    load  = 1'b1;
    step();
    load  = 1'b0;
    run_until(0);
    for (int i = 0; i < 32; i++) begin
      if (i / 4 >= 3) begin
        check("lz.suppressed", 32'(blank8), 32'd1);
      end else begin
        if (i % 4 == 0) check("lz.num", 32'(num8), 32'(nolz_tab[i / 4]));
        check("lz.blank", 32'(blank8), 32'(i % 4 == 0));
      end
      step();
    end
    lz_en = 1'b0;
    for (int i = 0; i < 32; i++) begin
      if (i % 4 == 0) check("nolz.num", 32'(num8), 32'(nolz_tab[i / 4]));
      check("nolz.blank", 32'(blank8), 32'(i % 4 == 0));
      step();
    end

    // Load on the edge where sel advances 2 -> 3.
    run_until(11);
    value = 32'hFFFF_FFFF;
    load  = 1'b1;
    step();
    load  = 1'b0;
    check("bnd.sel3", 32'(sel8), 32'd3);
    check("bnd.old",  32'(num8), 32'd0);
    repeat (4) step();
    check("bnd.sel4", 32'(sel8), 32'd4);
    check("bnd.new",  32'(num8), 32'hF);

    // Reset mid-slot (sel 5, count 2) with a simultaneous load that must be dropped.
    run_until(22);
    check("mid.pre_sel", 32'(sel8), 32'd5);
    rst   = 1'b1;
    load  = 1'b1;
    value = 32'h1357_2468;
    step();
    rst   = 1'b0;
    load  = 1'b0;
    check("mid.sel",   32'(sel8),   32'd0);
    check("mid.num",   32'(num8),   32'd0);
    check("mid.blank", 32'(blank8), 32'd1);
    for (int i = 0; i < 64; i++) begin
      step();
      check("mid.cleared8", 32'(num8), 32'd0);
      check("mid.cleared4", 32'(num4), 32'd0);
    end

    // Four-digit instance with 0xBEEF.
    value = 32'h0000_BEEF;
    run_until(28);
    load  = 1'b1;
    step();
    load  = 1'b0;
    run_until(0);
    for (int i = 0; i < 48; i++) begin
      if (i < 16) begin
        check("beef.sel", 32'(sel4), 32'((i / 4) % 4));
        if (i % 4 == 0) check("beef.num", 32'(num4), 32'(beef_tab[i / 4]));
      end
      check("beef.sel_range", 32'(sel4 <= 3'd3), 32'd1);
      check("beef.tick", 32'(tick4), 32'(i % 16 == 0));
      step();
    end

    // Randomized traffic: loads, lz_en toggles, occasional resets.
    for (int i = 0; i < 3000; i++) begin
      rst   = ($urandom_range(0, 299) == 0);
      load  = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 15) == 0) lz_en = ~lz_en;
      value = $urandom() >> (4 * $urandom_range(0, 8));
      step();
    end
    rst  = 1'b0;
    load = 1'b0;
    repeat (40) step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
